// File: rtl/deadlock_watchdog_agg_if.sv
// Bundle of watchdog control inputs and deadlock report outputs between the
// co-sim harness (master) and deadlock_watchdog_agg (slave).
interface deadlock_watchdog_agg_if #(
  parameter int N_MON = 4,
  parameter int CNT_W = 16,
  parameter int IDX_W = 2
);
  logic             enable;
  logic [N_MON-1:0] block_sigs;
  logic             progress;
  logic             clear;
  logic             deadlock;
  logic [N_MON-1:0] blocked_mask;
  logic [IDX_W-1:0] blocked_idx;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state_o;
  logic [N_MON-1:0] hist_mask;

  modport master (
    output enable, block_sigs, progress, clear,
    input  deadlock, blocked_mask, blocked_idx, stall_cnt, state_o, hist_mask
  );

  modport slave (
    input  enable, block_sigs, progress, clear,
    output deadlock, blocked_mask, blocked_idx, stall_cnt, state_o, hist_mask
  );
endinterface

// File: rtl/deadlock_watchdog_agg.sv
// Aggregates per-monitor block flags and declares a sticky deadlock after THRESHOLD
// consecutive stalled cycles. Optional block-history capture under macro DEADLOCK_HIST_EN.
module deadlock_watchdog_agg #(
  parameter int N_MON     = 4,
  parameter int THRESHOLD = 8,
  parameter int CNT_W     = 16,
  parameter int IDX_W     = 2
) (
  input logic                   clock,
  input logic                   reset,
  deadlock_watchdog_agg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WATCH    = 2'd1,
    ST_SUSPECT  = 2'd2,
    ST_DEADLOCK = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR_LAST = CNT_W'(THRESHOLD - 1);
  localparam logic [CNT_W-1:0] THR_FULL = CNT_W'(THRESHOLD);

  // Lowest set bit wins, so the scan runs from the top down.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_MON-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = N_MON - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_e           state_q, state_d;
  logic             deadlock_q, deadlock_d;
  logic [N_MON-1:0] mask_q, mask_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stalled_s;

  assign stalled_s = (|bus.block_sigs) && !bus.progress;

  // Next-state and result-latch logic; clear outranks enable, which outranks detection.
  always_comb begin
    state_d    = state_q;
    deadlock_d = deadlock_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    if (bus.clear) begin
      state_d    = bus.enable ? ST_WATCH : ST_IDLE;
      deadlock_d = 1'b0;
      mask_d     = {N_MON{1'b0}};
      idx_d      = {IDX_W{1'b0}};
      cnt_d      = CNT_ZERO;
    end else if (!bus.enable) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WATCH;
          cnt_d   = CNT_ZERO;
        end
        ST_WATCH: begin
          if (stalled_s && (THRESHOLD == 1)) begin
            state_d    = ST_DEADLOCK;
            deadlock_d = 1'b1;
            mask_d     = bus.block_sigs;
            idx_d      = lowest_set(bus.block_sigs);
            cnt_d      = THR_FULL;
          end else if (stalled_s) begin
            state_d = ST_SUSPECT;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        ST_SUSPECT: begin
          if (!stalled_s) begin
            state_d = ST_WATCH;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == THR_LAST) begin
            state_d    = ST_DEADLOCK;
            deadlock_d = 1'b1;
            mask_d     = bus.block_sigs;
            idx_d      = lowest_set(bus.block_sigs);
            cnt_d      = THR_FULL;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DEADLOCK: begin
          // Keeps counting so the harness can see how long the hang lasted; never wraps.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      deadlock_q <= 1'b0;
      mask_q     <= {N_MON{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      cnt_q      <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      deadlock_q <= deadlock_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef DEADLOCK_HIST_EN
  logic [N_MON-1:0] hist_q, hist_d;
  logic             hist_load_s;
  logic             hist_accum_s;

  // Window opens on the first stalled cycle out of WATCH; the declaring cycle is folded in.
  assign hist_load_s  = !bus.clear && bus.enable && (state_q == ST_WATCH) && stalled_s;
  assign hist_accum_s = !bus.clear && bus.enable && (state_q == ST_SUSPECT) && stalled_s;

  // History next-value selection.
  always_comb begin
    hist_d = hist_q;
    if (bus.clear) begin
      hist_d = {N_MON{1'b0}};
    end else if (hist_load_s) begin
      hist_d = bus.block_sigs;
    end else if (hist_accum_s) begin
      hist_d = hist_q | bus.block_sigs;
    end else begin
      hist_d = hist_q;
    end
  end

  // History register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hist_q <= {N_MON{1'b0}};
    end else begin
      hist_q <= hist_d;
    end
  end

  assign bus.hist_mask = hist_q;
`else
  assign bus.hist_mask = {N_MON{1'b0}};
`endif

  assign bus.state_o      = state_q;
  assign bus.deadlock     = deadlock_q;
  assign bus.blocked_mask = mask_q;
  assign bus.blocked_idx  = idx_q;
  assign bus.stall_cnt    = cnt_q;

endmodule

// File: tb/tb_deadlock_watchdog_agg.sv
// Directed scoreboard bench for deadlock_watchdog_agg (N_MON=4, THRESHOLD=8, CNT_W=16).
module tb_deadlock_watchdog_agg;

  typedef struct {
    int          cyc;
    string       nm;
    logic [1:0]  st;
    logic        dl;
    logic [3:0]  m;
    logic [1:0]  ix;
    logic [15:0] cn;
    logic [3:0]  h;
  } exp_t;

  logic clock;
  logic reset;
  int   cycle_cnt = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  exp_t sb[$];

  deadlock_watchdog_agg_if #(.N_MON(4), .CNT_W(16), .IDX_W(2)) bus_if ();

  deadlock_watchdog_agg #(
    .N_MON(4), .THRESHOLD(8), .CNT_W(16), .IDX_W(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic drive(input logic r, input logic e, input logic [3:0] b,
                       input logic p, input logic c);
    @(negedge clock);
    reset             = r;
    bus_if.enable     = e;
    bus_if.block_sigs = b;
    bus_if.progress   = p;
    bus_if.clear      = c;
  endtask

  // Expected outputs after the posedge that samples the inputs just driven.
  task automatic chk(input string nm, input logic [1:0] st, input logic dl,
                     input logic [3:0] m, input logic [1:0] ix,
                     input logic [15:0] cn, input logic [3:0] h);
    exp_t e;
    e.cyc = cycle_cnt + 1;
    e.nm  = nm;
    e.st  = st;
    e.dl  = dl;
    e.m   = m;
    e.ix  = ix;
    e.cn  = cn;
`ifdef DEADLOCK_HIST_EN
    e.h   = h;
`else
    e.h   = 4'b0000;
`endif
    sb.push_back(e);
  endtask

  // Monitor: compares the head expectation once its cycle has been reached.
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc != cycle_cnt) begin
        n_fail++;
        $display("FAIL %s: compared at cycle %0d, required cycle %0d", e.nm, cycle_cnt, e.cyc);
      end else if (bus_if.state_o !== e.st || bus_if.deadlock !== e.dl ||
                   bus_if.blocked_mask !== e.m || bus_if.blocked_idx !== e.ix ||
                   bus_if.stall_cnt !== e.cn || bus_if.hist_mask !== e.h) begin
        n_fail++;
        $display("FAIL %s: got st=%0d dl=%b mask=%b idx=%0d cnt=%0d hist=%b, want st=%0d dl=%b mask=%b idx=%0d cnt=%0d hist=%b",
                 e.nm, bus_if.state_o, bus_if.deadlock, bus_if.blocked_mask, bus_if.blocked_idx,
                 bus_if.stall_cnt, bus_if.hist_mask, e.st, e.dl, e.m, e.ix, e.cn, e.h);
      end
    end
  end

  initial begin
    logic [3:0] rot;
    reset             = 1'b0;
    bus_if.enable     = 1'b1;
    bus_if.block_sigs = 4'hF;
    bus_if.progress   = 1'b0;
    bus_if.clear      = 1'b0;

    // Reset with all monitors blocked, then release.
    drive(1'b0, 1'b1, 4'hF, 1'b0, 1'b0); chk("rst1", 2'd0, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);
    drive(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'hF, 1'b0, 1'b0); chk("rst3", 2'd0, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);
    drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b0); chk("release", 2'd1, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);

    // Single monitor held blocked: declare on the 8th stalled edge.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 4'b0100, 1'b0, 1'b0);
      if (i < 8) chk("hold_cnt", 2'd2, 1'b0, 4'h0, 2'd0, 16'(i), 4'b0100);
      else       chk("hold_decl", 2'd3, 1'b1, 4'b0100, 2'd2, 16'd8, 4'b0100);
    end
    drive(1'b1, 1'b1, 4'h0, 1'b1, 1'b0); chk("sticky1", 2'd3, 1'b1, 4'b0100, 2'd2, 16'd9, 4'b0100);
    drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b0); chk("sticky2", 2'd3, 1'b1, 4'b0100, 2'd2, 16'd10, 4'b0100);

    // Clear while all blocked, then redeclare 8 cycles later.
    drive(1'b1, 1'b1, 4'hF, 1'b0, 1'b1); chk("clear_dl", 2'd1, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
      if (i == 1)      chk("recount1", 2'd2, 1'b0, 4'h0, 2'd0, 16'd1, 4'hF);
      else if (i == 8) chk("redecl", 2'd3, 1'b1, 4'hF, 2'd0, 16'd8, 4'hF);
    end

    // Enable low holds results; clear while disabled stays IDLE.
    drive(1'b1, 1'b0, 4'hF, 1'b0, 1'b0); chk("en_low", 2'd0, 1'b1, 4'hF, 2'd0, 16'd0, 4'hF);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b1); chk("clr_idle", 2'd0, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);
    drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b0); chk("reenable", 2'd1, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);
    drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b0); chk("watch_nb", 2'd1, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);

    // Progress with block restarts the count.
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    chk("pre_prog", 2'd2, 1'b0, 4'h0, 2'd0, 16'd5, 4'b0001);
    drive(1'b1, 1'b1, 4'b0001, 1'b1, 1'b0); chk("progress", 2'd1, 1'b0, 4'h0, 2'd0, 16'd0, 4'b0001);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
      if (i == 1)      chk("post_prog1", 2'd2, 1'b0, 4'h0, 2'd0, 16'd1, 4'b0001);
      else if (i == 7) chk("post_prog7", 2'd2, 1'b0, 4'h0, 2'd0, 16'd7, 4'b0001);
      else if (i == 8) chk("post_prog8", 2'd3, 1'b1, 4'b0001, 2'd0, 16'd8, 4'b0001);
    end
    drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b1); chk("clear2", 2'd1, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);

    // Rotating block bits keep the count alive.
    for (int i = 1; i <= 8; i++) begin
      rot = (i <= 3) ? 4'b0001 : ((i <= 6) ? 4'b0010 : 4'b1000);
      drive(1'b1, 1'b1, rot, 1'b0, 1'b0);
      if (i == 3)      chk("rot3", 2'd2, 1'b0, 4'h0, 2'd0, 16'd3, 4'b0001);
      else if (i == 6) chk("rot6", 2'd2, 1'b0, 4'h0, 2'd0, 16'd6, 4'b0011);
      else if (i == 8) chk("rot_decl", 2'd3, 1'b1, 4'b1000, 2'd3, 16'd8, 4'b1011);
    end
    drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b1); chk("clear3", 2'd1, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);

    // Clear on what would be the declaring cycle wins.
    for (int i = 1; i <= 7; i++) drive(1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
    chk("pre_win", 2'd2, 1'b0, 4'h0, 2'd0, 16'd7, 4'b0010);
    drive(1'b1, 1'b1, 4'b0010, 1'b0, 1'b1); chk("clr_win", 2'd1, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
      if (i == 1)      chk("restart1", 2'd2, 1'b0, 4'h0, 2'd0, 16'd1, 4'b0010);
      else if (i == 6) chk("restart6", 2'd2, 1'b0, 4'h0, 2'd0, 16'd6, 4'b0010);
    end

    // Reset mid-SUSPECT.
    drive(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0); chk("mid_rst", 2'd0, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);
    drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);    chk("post_rst", 2'd1, 1'b0, 4'h0, 2'd0, 16'd0, 4'h0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
